keypad_scanner: RTL and testbench



---
 rtl/microwave_pkg.sv | 33 +++
 rtl/keypad_debouncer.sv | 121 ++++++++++++
 rtl/keypad_scanner.sv | 124 ++++++++++++
 tb/tb_keypad_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared microwave-controller definitions: keypad codes, debouncer states, row/column key map.
package microwave_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_MULTI = 4'hE;
  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    PRESSED = 2'd2
  } deb_state_e;

  // Rows 0..2 hold digits 1..9; row 3 is * 0 #. Column 3 does not exist.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_NONE;
    if (col != 2'd3) begin
      if (row != 2'd3) begin
        code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end else begin
        case (col)
          2'd0:    code = KEY_STAR;
          2'd1:    code = 4'd0;
          default: code = KEY_HASH;
        endcase
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-level press/release debouncer: a code must repeat DEBOUNCE_FRAMES frames to be accepted or dropped.
// Outputs register on the frame_vld cycle; key_strobe is a single-cycle pulse per accepted press.
module keypad_debouncer
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_vld,
  input  logic [3:0] frame_code,
  output logic [3:0] held_code,
  output logic       key_strobe
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DF_C  = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  deb_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_q, rel_d;
  logic          strobe_q, strobe_d;

  logic          is_key;
  logic [CW-1:0] cnt_inc, rel_inc;

  always_comb begin
    is_key  = (frame_code != KEY_NONE) && (frame_code != KEY_MULTI);
    cnt_inc = (cnt_q == DF_C) ? cnt_q : cnt_q + ONE_C;
    rel_inc = (rel_q == DF_C) ? rel_q : rel_q + ONE_C;

    state_d  = state_q;
    cand_d   = cand_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    strobe_d = 1'b0;

    if (frame_vld) begin
      case (state_q)
        IDLE: begin
          if (is_key) begin
            cand_d = frame_code;
            if (DF_C == ONE_C) begin
              state_d  = PRESSED;
              held_d   = frame_code;
              strobe_d = 1'b1;
              cnt_d    = '0;
              rel_d    = '0;
            end else begin
              state_d = PEND;
              cnt_d   = ONE_C;
            end
          end
        end
        PEND: begin
          if (is_key && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_C) begin
              state_d  = PRESSED;
              held_d   = cand_q;
              strobe_d = 1'b1;
              rel_d    = '0;
            end
          end else if (is_key) begin
            cand_d = frame_code;
            cnt_d  = ONE_C;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          // Any code other than the held one, including another digit, counts toward release.
          if (frame_code == cand_q) begin
            rel_d = '0;
          end else begin
            rel_d = rel_inc;
            if (rel_inc == DF_C) begin
              state_d = IDLE;
              held_d  = KEY_NONE;
              cnt_d   = '0;
              rel_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          held_d  = KEY_NONE;
          cnt_d   = '0;
          rel_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cand_q   <= KEY_NONE;
      held_q   <= KEY_NONE;
      cnt_q    <= '0;
      rel_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      strobe_q <= strobe_d;
    end
  end

  assign held_code  = held_q;
  assign key_strobe = strobe_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row drive, 2-flop column sync, per-frame code resolution, debounced one-hot digit out.
// Outputs update the cycle after the row-3 sample; KEYPAD_FUNC_EN adds start_key (#) and clear_key (*).
module keypad_scanner
  import microwave_pkg::*;
#(
  parameter int SCAN_DIV        = 250,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] cols_n,
  output logic [3:0] rows_n,
  output logic [9:0] keypad,
  output logic       key_strobe
`ifdef KEYPAD_FUNC_EN
  ,
  output logic       start_key,
  output logic       clear_key
`endif
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [2:0]    sync1_q, sync2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;

  logic          slot_end;
  logic          frame_vld;
  logic [3:0]    frame_code;
  logic [1:0]    row_cnt;
  logic [3:0]    row_code;
  logic [3:0]    col_code;
  logic          col_counts;
  logic [2:0]    tot_cnt;
  logic [1:0]    tot_sat;
  logic [3:0]    tot_code;
  logic [3:0]    held_code;

  always_comb begin
    slot_end   = (slot_q == SLOT_LAST);
    row_cnt    = 2'd0;
    row_code   = KEY_NONE;
    col_code   = KEY_NONE;
    col_counts = 1'b0;
    for (int c = 0; c < 3; c++) begin
      col_code = key_map(row_q, 2'(c));
`ifdef KEYPAD_FUNC_EN
      col_counts = 1'b1;
`else
      col_counts = (col_code != KEY_STAR) && (col_code != KEY_HASH);
`endif
      if (!sync2_q[c] && col_counts) begin
        row_cnt  = row_cnt + 2'd1;
        row_code = col_code;
      end
    end

    // Contact count only needs to distinguish 0, 1 and "more than one".
    tot_cnt  = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
    tot_sat  = (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];
    tot_code = (row_cnt == 2'd1) ? row_code : acc_code_q;

    frame_vld  = slot_end && (row_q == 2'd3);
    frame_code = (tot_sat == 2'd0) ? KEY_NONE :
                 (tot_sat == 2'd1) ? tot_code : KEY_MULTI;

    slot_d     = slot_end ? '0 : slot_q + SW'(1);
    row_d      = slot_end ? row_q + 2'd1 : row_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (slot_end) begin
      acc_cnt_d  = frame_vld ? 2'd0 : tot_sat;
      acc_code_d = frame_vld ? KEY_NONE : tot_code;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      slot_q     <= '0;
      row_q      <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= KEY_NONE;
    end else begin
      sync1_q    <= cols_n;
      sync2_q    <= sync1_q;
      slot_q     <= slot_d;
      row_q      <= row_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  assign rows_n = ~(4'b0001 << row_q);

  keypad_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debouncer (
    .clock     (clock),
    .resetn    (resetn),
    .frame_vld (frame_vld),
    .frame_code(frame_code),
    .held_code (held_code),
    .key_strobe(key_strobe)
  );

  always_comb begin
    keypad = '0;
    for (int d = 0; d < 10; d++) begin
      keypad[d] = (held_code == 4'(d));
    end
  end

`ifdef KEYPAD_FUNC_EN
  assign start_key = (held_code == KEY_HASH);
  assign clear_key = (held_code == KEY_STAR);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;

  localparam int FRAME = 16;
`ifdef KEYPAD_FUNC_EN
  localparam bit FUNC = 1'b1;
`else
  localparam bit FUNC = 1'b0;
`endif

  // Key matrix bit index = row*3 + col.
  localparam logic [11:0] K0 = 12'h400, K1 = 12'h001, K2 = 12'h002, K3 = 12'h004;
  localparam logic [11:0] K4 = 12'h008, K5 = 12'h010, K6 = 12'h020, K7 = 12'h040;
  localparam logic [11:0] K8 = 12'h080, K9 = 12'h100, KSTAR = 12'h200, KHASH = 12'h800;

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] cols_n;
  logic [3:0] rows_n;
  logic [9:0] keypad;
  logic       key_strobe;
  logic       start_key;
  logic       clear_key;
  logic [11:0] keys;

  int compared   = 0;
  int mismatched = 0;
  int strobe_cnt = 0;
  logic prev_strobe = 1'b0;

  typedef struct {
    logic [11:0] keys;
    int          frames;
    logic [9:0]  kp;
    int          strobes;
    logic        st;
    logic        cl;
  } vec_t;

  vec_t vq[$];

  always #5 clock = ~clock;

  always_comb begin
    cols_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!rows_n[r] && keys[r*3+c]) cols_n[c] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cols_n    (cols_n),
    .rows_n    (rows_n),
    .keypad    (keypad),
    .key_strobe(key_strobe)
`ifdef KEYPAD_FUNC_EN
    ,
    .start_key (start_key),
    .clear_key (clear_key)
`endif
  );

`ifndef KEYPAD_FUNC_EN
  assign start_key = 1'b0;
  assign clear_key = 1'b0;
`endif

  function automatic logic [9:0] oh(input int d);
    logic [9:0] v;
    v = 10'd1;
    return v << d;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %0h required %0h", name, idx, got, exp);
    end
  endtask

  // Continuous invariants: keypad zero/one-hot, strobe never two cycles running.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      compared++;
      if (!$onehot0(keypad) || (key_strobe && prev_strobe)) begin
        mismatched++;
        $display("FAIL invariant: keypad %b strobe %b prev_strobe %b", keypad, key_strobe, prev_strobe);
      end
      if (key_strobe) strobe_cnt++;
      prev_strobe = key_strobe;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  initial begin
    logic [3:0] exp_rows;
    vec_t v;

    vq.push_back('{keys: 12'h000,     frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 1, kp: oh(5), strobes: 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 2, kp: oh(5), strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 2, kp: oh(5), strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 1, kp: oh(5), strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 1, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K5,          frames: 1, kp: oh(5), strobes: 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K1 | K9,     frames: 4, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K1,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K1,          frames: 1, kp: oh(1), strobes: 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K7,          frames: 3, kp: oh(7), strobes: 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K8,          frames: 2, kp: oh(7), strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K8,          frames: 1, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K8,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K8,          frames: 1, kp: oh(8), strobes: 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: KSTAR,       frames: 3, kp: 10'd0, strobes: FUNC ? 1 : 0, st: 1'b0, cl: FUNC});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: KSTAR | K0,  frames: 3, kp: FUNC ? 10'd0 : oh(0), strobes: FUNC ? 0 : 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K2,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K3,          frames: 2, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K3,          frames: 1, kp: oh(3), strobes: 1, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: KHASH,       frames: 3, kp: 10'd0, strobes: FUNC ? 1 : 0, st: FUNC, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: K4 | K6,     frames: 3, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});
    vq.push_back('{keys: 12'h000,     frames: 1, kp: 10'd0, strobes: 0, st: 1'b0, cl: 1'b0});

    resetn = 1'b0;
    keys   = 12'h000;
    repeat (2) @(negedge clock);
    check("reset_rows", 0, 32'(rows_n), 32'h0000000E);
    check("reset_keypad", 0, 32'(keypad), 32'h0);
    check("reset_strobe", 0, 32'(key_strobe), 32'h0);
`ifdef KEYPAD_FUNC_EN
    check("reset_start", 0, 32'(start_key), 32'h0);
    check("reset_clear", 0, 32'(clear_key), 32'h0);
`endif

    // Released at a negedge so the next posedge starts slot 0 of row 0.
    resetn = 1'b1;
    for (int n = 1; n <= FRAME; n++) begin
      @(negedge clock);
      exp_rows = ~(4'b0001 << ((n / 4) % 4));
      check("rows_walk", n, 32'(rows_n), 32'(exp_rows));
    end
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      keys = v.keys;
      strobe_cnt = 0;
      repeat (FRAME * v.frames) @(negedge clock);
      #1;
      check("keypad", i, 32'(keypad), 32'(v.kp));
      check("strobes", i, 32'(strobe_cnt), 32'(v.strobes));
`ifdef KEYPAD_FUNC_EN
      check("start_key", i, 32'(start_key), 32'(v.st));
      check("clear_key", i, 32'(clear_key), 32'(v.cl));
`endif
    end

    // Reset in the middle of a held press, then a fresh debounce from row 0.
    keys = K5;
    strobe_cnt = 0;
    repeat (FRAME * 3) @(negedge clock);
    #1;
    check("pre_reset_keypad", 0, 32'(keypad), 32'(oh(5)));
    check("pre_reset_strobes", 0, 32'(strobe_cnt), 32'd1);
    repeat (5) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midreset_keypad", 0, 32'(keypad), 32'h0);
    check("midreset_rows", 0, 32'(rows_n), 32'h0000000E);
    @(negedge clock);
    resetn = 1'b1;
    strobe_cnt = 0;
    repeat (FRAME * 2) @(negedge clock);
    #1;
    check("post_reset_keypad", 2, 32'(keypad), 32'h0);
    check("post_reset_strobes", 2, 32'(strobe_cnt), 32'd0);
    repeat (FRAME) @(negedge clock);
    #1;
    check("post_reset_keypad", 3, 32'(keypad), 32'(oh(5)));
    check("post_reset_strobes", 3, 32'(strobe_cnt), 32'd1);

    keys = 12'h000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
